// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer for the single-cycle MIPS datapath. Each cycle it
//   selects the next fetch address. The choices are: sequential, a signed
//   relative branch, an absolute jump, a register jump, a call and a return.
//   Call and return use an internal circular return-address stack (RAS). A
//   stall input holds all state for the cycle.
//
// Ports
//   pb_clk_debounced  clock, all state updates on the rising edge
//   rst_general       asynchronous, active-high reset
//   stall             hold pc, RAS and flags this cycle (overrides pc_op)
//   pc_op             0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG, 4 CALL, 5 RET, 6-7 SEQ
//   take_branch       branch condition, used only for BRANCH
//   immediate         signed branch offset, sign-extended to PC_W
//   target            absolute address for JUMP, CALL and JREG
//   pc                current fetch address (registered)
//   pc_next           combinational value pc takes at the next edge
//   ras_count         number of valid RAS entries
//   ras_empty         ras_count == 0
//   ras_full          ras_count == RAS_DEPTH
//   ras_overflow      sticky: a CALL occurred while the RAS was full
//   ras_underflow     sticky: a RET occurred while the RAS was empty
module pc_sequencer #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned IMM_W     = 8,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                           pb_clk_debounced,
    input  logic                           rst_general,
    input  logic                           stall,
    input  logic [2:0]                     pc_op,
    input  logic                           take_branch,
    input  logic [IMM_W-1:0]               immediate,
    input  logic [PC_W-1:0]                target,
    output logic [PC_W-1:0]                pc,
    output logic [PC_W-1:0]                pc_next,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_JREG   = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } pc_op_e;

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_top;
    logic [PTR_W-1:0] top_inc;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  imm_sext;
    logic             do_push;
    logic             do_pop;
    logic             underflow_set;

    assign pc_inc    = pc + PC_W'(1);
    // The size cast of a signed operand sign-extends. This also holds when IMM_W == PC_W.
    assign imm_sext  = PC_W'($signed(immediate));
    // RAS_DEPTH is a power of 2, so the pointer wraps naturally.
    assign top_inc   = ras_top + PTR_W'(1);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

    always_comb begin
        pc_next       = pc;
        do_push       = 1'b0;
        do_pop        = 1'b0;
        underflow_set = 1'b0;
        if (!stall) begin
            case (pc_op)
                OP_SEQ:    pc_next = pc_inc;
                OP_BRANCH: pc_next = take_branch ? (pc + imm_sext) : pc_inc;
                OP_JUMP,
                OP_JREG:   pc_next = target;
                OP_CALL: begin
                    pc_next = target;
                    do_push = 1'b1;
                end
                OP_RET: begin
                    if (ras_empty) begin
                        pc_next       = pc_inc;
                        underflow_set = 1'b1;
                    end else begin
                        pc_next = ras_mem[ras_top];
                        do_pop  = 1'b1;
                    end
                end
                default:   pc_next = pc_inc;
            endcase
        end
    end

    always_ff @(posedge pb_clk_debounced or posedge rst_general) begin
        if (rst_general) begin
            pc            <= PC_W'(RESET_PC);
            ras_top       <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc <= pc_next;
            if (do_push) begin
                // When full, top+1 lands on the oldest entry, so it is overwritten.
                ras_top <= top_inc;
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end
            if (do_pop) begin
                ras_top   <= ras_top - PTR_W'(1);
                ras_count <= ras_count - CNT_W'(1);
            end
            if (underflow_set) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    // Entry storage is not reset; its contents are meaningless while count is 0.
    always_ff @(posedge pb_clk_debounced) begin
        if (do_push && !rst_general) begin
            ras_mem[top_inc] <= pc_inc;
        end
    end

endmodule
